// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential fetch with one-cycle memory latency, table-driven
// jumps, skip-one branches and halt, under a small IDLE/RUN/HALTED controller.
module instr_fetch #(
    parameter int pc_width    = 10,
    parameter int instr_width = 9,
    parameter int lut_depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [pc_width-1:0]    start_addr,
    output logic [pc_width-1:0]    instr_addr,
    output logic                   instr_re,
    input  logic [instr_width-1:0] instr_rdata,
    output logic [instr_width-1:0] instruction,
    output logic                   instr_valid,
    output logic [pc_width-1:0]    instr_pc,
    input  logic                   jump,
    input  logic                   halt,
    input  logic [7:0]             imm,
    input  logic                   branch_taken,
    input  logic                   lut_we,
    input  logic [5:0]             lut_addr,
    input  logic [pc_width-1:0]    lut_wdata,
    output logic                   done,
    output logic [15:0]            cycle_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]          state;
    logic [pc_width-1:0] fetch_ptr;
    logic                inflight_valid;
    logic [pc_width-1:0] inflight_pc;
    logic                done_q;
    logic [15:0]         count;
    logic [pc_width-1:0] lut [lut_depth];

    logic                running;
    logic                live;
    logic                do_halt;
    logic                do_jump;
    logic                do_branch;
    logic [pc_width-1:0] jump_target;
    logic [pc_width-1:0] branch_target;
    logic                imm_unused;

    assign imm_unused = ^imm[7:6];

    // Decoder controls only act on an instruction that is actually live.
    assign running       = (state == RUN);
    assign live          = running && inflight_valid;
    assign do_halt       = live && halt;
    assign do_jump       = live && jump && !halt;
    assign do_branch     = live && branch_taken && !halt && !jump;
    assign branch_target = inflight_pc + pc_width'(2);

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        jump_target = '0;
        if (int'(imm[5:0]) < lut_depth) begin
            jump_target = lut[imm[5:0]];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (reset) begin
            state          <= IDLE;
            fetch_ptr      <= '0;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
            done_q         <= 1'b0;
            count          <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state          <= RUN;
                        fetch_ptr      <= start_addr;
                        inflight_valid <= 1'b0;
                        done_q         <= 1'b0;
                        count          <= '0;
                    end
                end
                RUN: begin
                    if (count != 16'hFFFF) begin
                        count <= count + 16'd1;
                    end
                    if (do_halt) begin
                        state          <= HALTED;
                        done_q         <= 1'b1;
                        inflight_valid <= 1'b0;
                    end else if (do_jump) begin
                        fetch_ptr      <= jump_target;
                        inflight_valid <= 1'b0;
                    end else if (do_branch) begin
                        fetch_ptr      <= branch_target;
                        inflight_valid <= 1'b0;
                    end else begin
                        fetch_ptr      <= fetch_ptr + pc_width'(1);
                        inflight_valid <= 1'b1;
                        inflight_pc    <= fetch_ptr;
                    end
                end
                default: begin
                    state          <= IDLE;
                    inflight_valid <= 1'b0;
                end
            endcase
        end
    end

    // Table read above is combinational, so a same-edge write is seen only afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the jump table is small and must read zero after reset, so it is cleared
            // explicitly; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < lut_depth; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we && (int'(lut_addr) < lut_depth)) begin
            lut[lut_addr] <= lut_wdata;
        end
    end

    assign instr_addr  = fetch_ptr;
    assign instr_re    = running;
    assign instr_valid = live;
    assign instr_pc    = inflight_pc;
    assign instruction = instr_rdata;
    assign done        = done_q;
    assign cycle_count = count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model of the fetch stream.
module tb_instr_fetch;

    localparam int pc_mod = 1024;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  start_addr;
    logic [9:0]  instr_addr;
    logic        instr_re;
    logic [8:0]  instr_rdata;
    logic [8:0]  instruction;
    logic        instr_valid;
    logic [9:0]  instr_pc;
    logic        jump;
    logic        halt;
    logic [7:0]  imm;
    logic        branch_taken;
    logic        lut_we;
    logic [5:0]  lut_addr;
    logic [9:0]  lut_wdata;
    logic        done;
    logic [15:0] cycle_count;

    instr_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .instr_addr   (instr_addr),
        .instr_re     (instr_re),
        .instr_rdata  (instr_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_pc     (instr_pc),
        .jump         (jump),
        .halt         (halt),
        .imm          (imm),
        .branch_taken (branch_taken),
        .lut_we       (lut_we),
        .lut_addr     (lut_addr),
        .lut_wdata    (lut_wdata),
        .done         (done),
        .cycle_count  (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory with one cycle of read latency.
    logic [8:0] mem [pc_mod];
    always @(posedge clk) instr_rdata <= mem[instr_addr];

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    endtask

    // Behavioural model: whether the program runs, the next address to fetch, and the
    // address whose data arrives this cycle (-1 when nothing live arrives).
    bit m_running = 1'b0;
    bit m_done    = 1'b0;
    int m_next    = 0;
    int m_deliv   = -1;
    int m_count   = 0;
    int m_lut [64];

    task automatic model_step();
        int target;
        if (reset) begin
            m_running = 1'b0;
            m_done    = 1'b0;
            m_next    = 0;
            m_deliv   = -1;
            m_count   = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
            return;
        end
        target = m_lut[imm[5:0]];
        if (!m_running) begin
            if (start) begin
                m_running = 1'b1;
                m_done    = 1'b0;
                m_next    = int'(start_addr);
                m_deliv   = -1;
                m_count   = 0;
            end
        end else begin
            m_count = (m_count < 65535) ? m_count + 1 : 65535;
            if (m_deliv >= 0 && halt) begin
                m_running = 1'b0;
                m_done    = 1'b1;
                m_deliv   = -1;
            end else if (m_deliv >= 0 && jump) begin
                m_next  = target;
                m_deliv = -1;
            end else if (m_deliv >= 0 && branch_taken) begin
                m_next  = (m_deliv + 2) % pc_mod;
                m_deliv = -1;
            end else begin
                m_deliv = m_next;
                m_next  = (m_next + 1) % pc_mod;
            end
        end
        if (lut_we) m_lut[lut_addr] = int'(lut_wdata);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            check("instr_re", int'(instr_re), int'(m_running));
            check("instr_valid", int'(instr_valid), int'(m_running && m_deliv >= 0));
            if (m_running && m_deliv >= 0) begin
                check("instr_pc", int'(instr_pc), m_deliv);
                check("instruction", int'(instruction), int'(mem[m_deliv]));
            end
            if (m_running) check("instr_addr", int'(instr_addr), m_next);
            check("done", int'(done), int'(m_done));
            check("cycle_count", int'(cycle_count), m_count);
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        reset        = 1'b0;
        start        = 1'b0;
        jump         = 1'b0;
        halt         = 1'b0;
        branch_taken = 1'b0;
        lut_we       = 1'b0;
        imm          = '0;
        #1;
    endtask

    task automatic wait_pc(input int target, input int budget);
        logic [9:0] t10;
        t10 = target[9:0];
        for (int i = 0; i < budget; i++) begin
            if (instr_valid && instr_pc == t10) return;
            next_cycle();
        end
        check("wait_pc_timeout", int'({instr_valid, instr_pc}), int'({1'b1, t10}));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  int'(instr_addr),  0);
        check({tag, "_re"},    int'(instr_re),    0);
        check({tag, "_valid"}, int'(instr_valid), 0);
        check({tag, "_pc"},    int'(instr_pc),    0);
        check({tag, "_done"},  int'(done),        0);
        check({tag, "_count"}, int'(cycle_count), 0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; start_addr = '0; jump = 1'b0; halt = 1'b0;
        imm = '0; branch_taken = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
        foreach (mem[i]) mem[i] = 9'($urandom);

        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b1;
        next_cycle();
        cmp_en = 1'b1;
        check_reset_outputs("reset");

        // Program the table while idle.
        lut_we = 1'b1; lut_addr = 6'd3; lut_wdata = 10'h040;
        next_cycle(); lut_we = 1'b1; lut_addr = 6'd5; lut_wdata = 10'h00E;
        next_cycle(); start_addr = 10'd5; start = 1'b1;

        // Sequential fetch from 5.
        next_cycle();
        check("seq_addr0", int'(instr_addr), 5);
        check("seq_valid0", int'(instr_valid), 0);
        check("seq_count0", int'(cycle_count), 0);
        next_cycle();
        check("seq_addr1", int'(instr_addr), 6);
        check("seq_pc1", int'(instr_pc), 5);
        check("seq_count1", int'(cycle_count), 1);
        next_cycle();
        check("seq_addr2", int'(instr_addr), 7);
        check("seq_count2", int'(cycle_count), 2);

        // Jump through lut[3].
        wait_pc(8, 10); jump = 1'b1; imm = 8'h03;
        next_cycle();
        check("jump_bubble", int'(instr_valid), 0);
        check("jump_addr", int'(instr_addr), 'h040);
        next_cycle();
        check("jump_valid", int'(instr_valid), 1);
        check("jump_pc", int'(instr_pc), 'h040);

        // Detour to 0x00E, then branch at 0x010.
        jump = 1'b1; imm = 8'h05;
        wait_pc('h010, 10); branch_taken = 1'b1;
        next_cycle();
        check("branch_bubble", int'(instr_valid), 0);
        next_cycle();
        check("branch_pc", int'(instr_pc), 'h012);

        // Halt wins over jump and branch.
        wait_pc('h020, 20); halt = 1'b1; jump = 1'b1; branch_taken = 1'b1; imm = 8'h03;
        cnt = int'(cycle_count);
        next_cycle();
        check("halt_done", int'(done), 1);
        check("halt_re", int'(instr_re), 0);
        check("halt_count", int'(cycle_count), cnt + 1);
        next_cycle(); next_cycle();
        check("halt_frozen", int'(cycle_count), cnt + 1);

        // Restart at the top of memory; a jump with nothing live is ignored.
        start_addr = 10'h3FF; start = 1'b1;
        next_cycle();
        check("wrap_done", int'(done), 0);
        check("wrap_addr0", int'(instr_addr), 'h3FF);
        jump = 1'b1; imm = 8'h03;
        next_cycle();
        check("wrap_addr1", int'(instr_addr), 'h000);
        check("wrap_pc", int'(instr_pc), 'h3FF);

        // Same-edge write and jump use the old entry; the new one is seen afterwards.
        wait_pc('h002, 10); jump = 1'b1; imm = 8'h03;
        lut_we = 1'b1; lut_addr = 6'd3; lut_wdata = 10'h155;
        next_cycle(); next_cycle();
        check("old_entry_pc", int'(instr_pc), 'h040);
        jump = 1'b1; imm = 8'h03;
        next_cycle(); next_cycle();
        check("new_entry_pc", int'(instr_pc), 'h155);

        // start is ignored while running.
        start = 1'b1; start_addr = 10'h200;
        next_cycle();
        check("start_ignored", int'(instr_addr), 'h157);

        // Reset four cycles into a fresh run clears everything, including the table.
        halt = 1'b1;
        next_cycle(); start_addr = 10'h030; start = 1'b1;
        next_cycle(); next_cycle(); next_cycle(); next_cycle();
        reset = 1'b1;
        next_cycle();
        check_reset_outputs("midrun");
        start_addr = 10'h050; start = 1'b1;
        next_cycle(); next_cycle();
        jump = 1'b1; imm = 8'h03;
        next_cycle(); next_cycle();
        check("cleared_lut_pc", int'(instr_pc), 0);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset        = ($urandom_range(199) == 0);
            start        = ($urandom_range(19) == 0);
            start_addr   = 10'($urandom);
            halt         = ($urandom_range(39) == 0);
            jump         = ($urandom_range(11) == 0);
            branch_taken = ($urandom_range(7) == 0);
            imm          = 8'($urandom);
            lut_we       = ($urandom_range(5) == 0);
            lut_addr     = 6'($urandom);
            lut_wdata    = 10'($urandom);
        end
        next_cycle();
        #3;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
